// File: rtl/smbm_sched_pkg.sv
// Shared parameters, opcode and status encodings for the smbm request scheduler.
package smbm_sched_pkg;

    localparam int BIT_VEC_SIZE       = 8;
    localparam int BIT_VEC_SIZE_LOG   = 3;
    localparam int NUM_OF_METRICS     = 2;
    localparam int NUM_OF_METRICS_LOG = 1;

    localparam logic [2:0] SMBM_OP_ADD  = 3'b000;
    localparam logic [2:0] SMBM_OP_DEL  = 3'b001;
    localparam logic [2:0] SMBM_OP_READ = 3'b010;
    localparam logic [2:0] SMBM_OP_IDLE = 3'b111;

    localparam logic [2:0] OPIN_NONE = 3'b000;
    localparam logic [2:0] OPIN_FILT = 3'b010;
    localparam logic [2:0] OPIN_ALL  = 3'b101;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_REJECT  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [BIT_VEC_SIZE_LOG:0] OCC_FULL = (BIT_VEC_SIZE_LOG+1)'(BIT_VEC_SIZE);

    typedef enum logic [1:0] {
        REQ_ADD       = 2'b00,
        REQ_DEL       = 2'b01,
        REQ_READ_FILT = 2'b10,
        REQ_READ_ALL  = 2'b11
    } req_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic [2:0] smbm_opcode_of(input logic [1:0] op);
        case (op)
            REQ_ADD: return SMBM_OP_ADD;
            REQ_DEL: return SMBM_OP_DEL;
            default: return SMBM_OP_READ;
        endcase
    endfunction

    function automatic logic [2:0] opcode_in_of(input logic [1:0] op);
        case (op)
            REQ_READ_FILT: return OPIN_FILT;
            REQ_READ_ALL:  return OPIN_ALL;
            default:       return OPIN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/smbm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_REQ_LOG = 2
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ_LOG-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ_LOG-1:0] idx,
    output logic                   any
);

    // Scan farthest-first so the requester closest to rr_ptr overwrites the rest.
    always_comb begin
        int k;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (req[k]) begin
                idx = NUM_REQ_LOG'(k);
                any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = any && (idx == NUM_REQ_LOG'(gi));
    end

endmodule

// File: rtl/smbm_sched.sv
// Arbitrates requesters onto the smbm store, one command in flight, with
// occupancy-based rejection, a WAIT timeout and a tagged status response.
module smbm_sched
    import smbm_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_REQ_LOG = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [NUM_REQ-1:0][1:0]                        req_op,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE_LOG-1:0]       req_id,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS-1:0][7:0]    req_metric,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE-1:0]           req_in,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS_LOG-1:0]     req_metricX,
    output logic                                           smbm_rst,
    output logic [2:0]                                     smbm_opcode,
    output logic [2:0]                                     smbm_opcode_in,
    output logic [BIT_VEC_SIZE_LOG-1:0]                    smbm_id,
    output logic [NUM_OF_METRICS-1:0][7:0]                 smbm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]                        smbm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]                  smbm_metricX,
    input  logic                                           smbm_done,
    output logic                                           rsp_valid,
    output logic [NUM_REQ_LOG-1:0]                         rsp_idx,
    output logic [1:0]                                     rsp_status,
    output logic [BIT_VEC_SIZE_LOG:0]                      occupancy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                            state_reg, state_next;
    logic [NUM_REQ_LOG-1:0]            rr_ptr_reg;
    logic [BIT_VEC_SIZE_LOG:0]         occ_reg;
    logic [1:0]                        op_reg;
    logic [BIT_VEC_SIZE_LOG-1:0]       id_reg;
    logic [NUM_OF_METRICS-1:0][7:0]    metric_reg;
    logic [BIT_VEC_SIZE-1:0]           in_reg;
    logic [NUM_OF_METRICS_LOG-1:0]     metricx_reg;
    logic [NUM_REQ_LOG-1:0]            idx_reg;
    logic [1:0]                        status_reg;
    logic [CNT_W-1:0]                  cnt_reg;
    logic [1:0]                        rst_sync_reg;

    logic [NUM_REQ-1:0]                arb_grant;
    logic [NUM_REQ_LOG-1:0]            arb_idx;
    logic                              arb_any;
    logic                              accept, reject, timeout_hit;
    logic [1:0]                        win_op;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .NUM_REQ_LOG (NUM_REQ_LOG)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr_reg),
        .grant  (arb_grant),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    // smbm reset: set immediately with rst_n, released two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_reg <= 2'b11;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
    assign smbm_rst = rst_sync_reg[1];

    assign win_op      = req_op[arb_idx];
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (arb_any && !smbm_rst) begin
                    accept     = 1'b1;
                    reject     = (win_op == REQ_ADD && occ_reg == OCC_FULL) ||
                                 (win_op == REQ_DEL && occ_reg == '0);
                    state_next = reject ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (smbm_done || timeout_hit) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            rr_ptr_reg  <= '0;
            occ_reg     <= '0;
            op_reg      <= '0;
            id_reg      <= '0;
            metric_reg  <= '0;
            in_reg      <= '0;
            metricx_reg <= '0;
            idx_reg     <= '0;
            status_reg  <= ST_OK;
            cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= win_op;
                id_reg      <= req_id[arb_idx];
                metric_reg  <= req_metric[arb_idx];
                in_reg      <= req_in[arb_idx];
                metricx_reg <= req_metricX[arb_idx];
                idx_reg     <= arb_idx;
                status_reg  <= reject ? ST_REJECT : ST_OK;
                rr_ptr_reg  <= (arb_idx == NUM_REQ_LOG'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state_reg == S_ISSUE) cnt_reg <= '0;
            else if (state_reg == S_WAIT) cnt_reg <= cnt_reg + 1'b1;
            // done wins over a timeout landing in the same cycle
            if (state_reg == S_WAIT) begin
                if (smbm_done) begin
                    status_reg <= ST_OK;
                    if (op_reg == REQ_ADD)      occ_reg <= occ_reg + 1'b1;
                    else if (op_reg == REQ_DEL) occ_reg <= occ_reg - 1'b1;
                end else if (timeout_hit) begin
                    status_reg <= ST_TIMEOUT;
                end
            end
        end
    end

    assign req_ready       = accept ? arb_grant : '0;
    assign smbm_opcode     = (state_reg == S_ISSUE) ? smbm_opcode_of(op_reg) : SMBM_OP_IDLE;
    assign smbm_opcode_in  = opcode_in_of(op_reg);
    assign smbm_id         = id_reg;
    assign smbm_metric_val = metric_reg;
    assign smbm_in         = in_reg;
    assign smbm_metricX    = metricx_reg;
    assign rsp_valid       = (state_reg == S_RESP);
    assign rsp_idx         = idx_reg;
    assign rsp_status      = status_reg;
    assign occupancy       = occ_reg;

endmodule

// File: doc/smbm_sched.md
# smbm_sched

Request scheduler and sequencer for the `smbm` sorted-metric store. It arbitrates round-robin between `NUM_REQ` requesters issuing ADD / DELETE / READ commands and drives the `smbm` opcode and argument pins with the one-cycle opcode pulse `smbm` requires. It waits for `smbm` `done`, tracks occupancy so that ADD-when-full and DELETE-when-empty are rejected before reaching the store, and returns a tagged status response. It also generates `smbm`'s synchronous active-high reset from the system reset.

## Interface
- `NUM_REQ`, default 4: number of requesters (≥2).
- `NUM_REQ_LOG`, default 2: clog2(`NUM_REQ`).
- `TIMEOUT`, default 15: WAIT cycles before a command is abandoned.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [NUM_REQ]  request pending, held until accepted.
- `req_ready`  out  [NUM_REQ]  one-hot accept pulse.
- `req_op`  in  [NUM_REQ][1:0]  00 ADD, 01 DELETE, 10 READ_FILT, 11 READ_ALL.
- `req_id`  in  [NUM_REQ][BIT_VEC_SIZE_LOG]  entry id.
- `req_metric`  in  [NUM_REQ][NUM_OF_METRICS][8]  metric values.
- `req_in`  in  [NUM_REQ][BIT_VEC_SIZE]  READ filter mask.
- `req_metricX`  in  [NUM_REQ][NUM_OF_METRICS_LOG]  READ sort metric.
- `smbm_rst`  out  1  to `smbm.rst`.
- `smbm_opcode`  out  3  to `smbm.opcode`.
- `smbm_opcode_in`  out  3  to `smbm.opcode_in`.
- `smbm_id`, `smbm_metric_val`, `smbm_in`, `smbm_metricX`  out  matching widths, to `smbm`.
- `smbm_done`  in  1  from `smbm.done`.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_idx`  out  NUM_REQ_LOG  requester served.
- `rsp_status`  out  2  00 OK, 01 REJECT, 10 TIMEOUT.
- `occupancy`  out  BIT_VEC_SIZE_LOG+1  live entry count.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid` is high, the round-robin winner is chosen starting at `rr_ptr`.
  - Pulse `req_ready[winner]` and latch op and args into holding registers.
  - Set `rr_ptr` = winner+1 mod `NUM_REQ`.
  - If the op is ADD with `occupancy`==BIT_VEC_SIZE, or DELETE with `occupancy`==0, set status REJECT and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE: drive `smbm_opcode` for exactly this cycle: ADD→000, DELETE→001, READ_*→010. Go to WAIT.
  - Outside ISSUE, `smbm_opcode`=3'b111, which is idle for `smbm`.
- `smbm_opcode_in`: 010 for READ_FILT, 101 for READ_ALL, 000 otherwise.
  - It and all `smbm_*` args come from the holding registers and stay stable from ISSUE through RESP.
- WAIT: a timeout counter is cleared on entry.
  - `smbm_done`=1 → status OK; ADD increments `occupancy`, DELETE decrements it, READ leaves it unchanged. Go to RESP.
  - Counter reaches `TIMEOUT` → status TIMEOUT, `occupancy` unchanged, go to RESP.
- RESP: assert `rsp_valid` with `rsp_idx` and `rsp_status`, then go to IDLE.
  - For READ OK, `smbm.out_list` is valid from this cycle until the next READ completes.
- Only one command is in flight. Requests arriving in non-IDLE states wait.

## Timing
- Reset values, while `rst_n`=0:
  - FSM=IDLE, `rr_ptr`=0, `occupancy`=0, holding registers=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_status`=00, `smbm_opcode`=3'b111, `smbm_rst`=1.
- `smbm_rst`: asserted asynchronously, deasserted synchronously through 2 flops.
- No request is accepted while `smbm_rst`=1.
- Latency, with accept at cycle 0:
  - ADD/DELETE: ISSUE at 1, `smbm_done` at 3, `rsp_valid` at 4.
  - READ: `smbm_done` at 2, `rsp_valid` at 3.
  - REJECT: `rsp_valid` at 1.
- Back-to-back throughput: next accept is the cycle after RESP. The ADD cycle period is 5.
- Requester handshake: `req_valid` stays high until `req_ready` is seen; args are sampled in the `req_ready` cycle.
- A `smbm_done` seen outside WAIT is ignored.
- `rst_n` asserted mid-command: the command is dropped with no response, and `smbm` is reset along with it.

## Structure
- Shared params package: `BIT_VEC_SIZE`, `BIT_VEC_SIZE_LOG`, `NUM_OF_METRICS`, `NUM_OF_METRICS_LOG`, plus new constants for the `smbm` opcodes (000/001/010/111), the `opcode_in` codes (010/101) and the status codes.
- Sub-module `rr_arbiter`: parameters `NUM_REQ`/`NUM_REQ_LOG`; inputs request vector and `rr_ptr`; outputs one-hot grant, index and `any`. It is combinational.

## Test plan
- Reset then ADD from requester 2 (id=5, metrics={10,20}):
  - `smbm_opcode`=000 for exactly 1 cycle.
  - `rsp_valid` 4 cycles after `req_ready`, `rsp_idx`=2, status OK, `occupancy`=1.
- Requesters 0, 1 and 3 all valid with READ_ALL → grants in order 0, 1, 3, then 0 again when re-requested. Each response has status OK and `smbm_opcode_in`=101.
- Fill to BIT_VEC_SIZE with ADDs, then one more ADD → REJECT 1 cycle after accept, no `smbm_opcode` pulse, `occupancy` unchanged.
- DELETE at `occupancy`=0 → REJECT. Then ADD followed by DELETE id=5 → `occupancy` goes 1 then 0.
- `smbm_done` stuck at 0 → TIMEOUT after 15 WAIT cycles, FSM back in IDLE, next request served.
- Drop `rst_n` during WAIT →
  - All outputs immediately at their reset values, `smbm_rst`=1.
  - `smbm_rst` stays high for 2 cycles after `rst_n` rises.
  - No stale `rsp_valid`.
